alu_shift_seq: RTL

ALU_SHIFT_SEQ -- requirements
Module: alu_shift_seq

---
 rtl/alu_shift_pkg.sv | 25 ++
 rtl/shift_carry_right_32.sv | 12 +
 rtl/alu_shift_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alu_shift_pkg.sv
// Shared definitions for the sequential shifter: op encodings, FSM states
// and the bit-reversal helper used to run left shifts on a right-only path.
package alu_shift_pkg;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Mirror a 32-bit word so a left shift becomes a right shift.
  function automatic logic [31:0] reverse32(input logic [31:0] value);
    logic [31:0] mirrored;
    for (int i = 0; i < 32; i++) begin
      mirrored[i] = value[31 - i];
    end
    return mirrored;
  endfunction

endpackage

// File: rtl/shift_carry_right_32.sv
// Combinational rotate-right-by-one stage; also exposes the bit that left
// the low end so callers can track the last shifted-out bit.
module shift_carry_right_32 (
  input  logic [31:0] in_data,
  output logic [31:0] out_data,
  output logic        shifted_out
);

  assign out_data    = {in_data[0], in_data[31:1]};
  assign shifted_out = in_data[0];

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle barrel-free shifter: performs SRL/SRA/SLL/ROR one bit per
// clock using a single rotate-right stage. Left shifts run on a
// bit-reversed copy of the operand and are reversed back on completion.
module alu_shift_seq
  import alu_shift_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [AMT_W-1:0]  amt,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  state_t             state, state_n;
  logic [1:0]         op_q, op_n;
  logic               sign_q, sign_n;
  logic [AMT_W-1:0]   count, count_n;
  logic [DATA_W-1:0]  work, work_n;
  logic               last_out, last_n;
  logic [DATA_W-1:0]  result_n;
  logic               carry_n;
  logic [DATA_W-1:0]  rotated;
  logic               step_out;
  logic [DATA_W-1:0]  stepped;

  shift_carry_right_32 u_step (
    .in_data     (work),
    .out_data    (rotated),
    .shifted_out (step_out)
  );

  // Apply the per-op override of the bit that wrapped into position 31.
  always_comb begin
    stepped = rotated;
    case (op_q)
      OP_SRL:  stepped[DATA_W-1] = 1'b0;
      OP_SLL:  stepped[DATA_W-1] = 1'b0;
      OP_SRA:  stepped[DATA_W-1] = sign_q;
      OP_ROR:  stepped[DATA_W-1] = rotated[DATA_W-1];
      default: stepped[DATA_W-1] = 1'b0;
    endcase
  end

  // Next-state and datapath update; result/carry load only when entering DONE.
  always_comb begin
    state_n  = state;
    op_n     = op_q;
    sign_n   = sign_q;
    count_n  = count;
    work_n   = work;
    last_n   = last_out;
    result_n = result;
    carry_n  = carry;
    case (state)
      ST_IDLE: begin
        if (start) begin
          op_n   = op;
          sign_n = a[DATA_W-1];
          if (op == OP_SLL) begin
            work_n = reverse32(a);
          end else begin
            work_n = a;
          end
          if (amt != {AMT_W{1'b0}}) begin
            count_n = amt;
            state_n = ST_SHIFT;
          end else begin
            count_n  = {AMT_W{1'b0}};
            last_n   = 1'b0;
            result_n = a;
            carry_n  = 1'b0;
            state_n  = ST_DONE;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_n  = stepped;
        last_n  = step_out;
        count_n = count - AMT_W'(1);
        if (count == AMT_W'(1)) begin
          state_n = ST_DONE;
          carry_n = step_out;
          if (op_q == OP_SLL) begin
            result_n = reverse32(stepped);
          end else begin
            result_n = stepped;
          end
        end else begin
          state_n = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs; reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= OP_SRL;
      sign_q   <= 1'b0;
      count    <= {AMT_W{1'b0}};
      work     <= {DATA_W{1'b0}};
      last_out <= 1'b0;
      result   <= {DATA_W{1'b0}};
      carry    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      op_q     <= op_n;
      sign_q   <= sign_n;
      count    <= count_n;
      work     <= work_n;
      last_out <= last_n;
      result   <= result_n;
      carry    <= carry_n;
      busy     <= (state_n != ST_IDLE);
      done     <= (state_n == ST_DONE);
    end
  end

endmodule
